// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - CP0 interrupt/exception controller: Count/Compare timer, Status/Cause/EPC,
// interrupt synchronizer and a two-state redirect FSM (IDLE -> FLUSH -> IDLE).
module int_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  hw_int,
    input  logic        wb_valid,
    input  logic        wb_syscall,
    input  logic        wb_eret,
    input  logic [31:0] wb_pc,
    input  logic        mtc0_wen,
    input  logic [7:0]  mtc0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [7:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic [32:0] exc_bus,
    output logic        cancel,
    output logic        wb_kill
);

    localparam logic [7:0] ADDR_COUNT   = 8'h48;
    localparam logic [7:0] ADDR_COMPARE = 8'h58;
    localparam logic [7:0] ADDR_STATUS  = 8'h60;
    localparam logic [7:0] ADDR_CAUSE   = 8'h68;
    localparam logic [7:0] ADDR_EPC     = 8'h70;

    typedef enum logic {S_IDLE, S_FLUSH} state_t;
    typedef enum logic [1:0] {EV_NONE, EV_INT, EV_SYS, EV_ERET} event_t;

    state_t      r_state;
    state_t      w_next;
    event_t      w_event;

    logic [4:0]  r_sync1;
    logic [4:0]  r_sync2;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;
    logic        r_flush_eret;

    logic [7:0]  w_ip;
    logic        w_int_pend;
    logic        w_mtc0;

    assign w_ip       = {r_ti, r_sync2, r_ip_sw};
    assign w_int_pend = r_ie & ~r_exl & (|(w_ip & r_im));
    assign w_mtc0     = mtc0_wen & wb_valid & ~wb_kill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_event = EV_NONE;
        wb_kill = 1'b0;
        cancel  = 1'b0;
        exc_bus = 33'd0;
        case (r_state)
            S_IDLE: begin
                if (wb_valid) begin
                    if (w_int_pend) begin
                        w_event = EV_INT;
                        wb_kill = 1'b1;
                    end else if (wb_syscall) begin
                        w_event = EV_SYS;
                    end else if (wb_eret) begin
                        w_event = EV_ERET;
                    end
                end
                if (w_event != EV_NONE) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // The WB slot now holds a younger, cancelled instruction.
                cancel  = 1'b1;
                wb_kill = 1'b1;
                exc_bus = {1'b1, (r_flush_eret ? r_epc : 32'd0)};
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1      <= 5'd0;
            r_sync2      <= 5'd0;
            r_count      <= 32'd0;
            r_compare    <= 32'd0;
            r_ti         <= 1'b0;
            r_im         <= 8'd0;
            r_exl        <= 1'b0;
            r_ie         <= 1'b0;
            r_ip_sw      <= 2'd0;
            r_exccode    <= 5'd0;
            r_epc        <= 32'd0;
            r_flush_eret <= 1'b0;
        end else begin
            r_sync1 <= hw_int;
            r_sync2 <= r_sync1;

            if (w_mtc0 && mtc0_addr == ADDR_COUNT) begin
                r_count <= mtc0_wdata;
            end else begin
                r_count <= r_count + 32'd1;
            end

            // A Compare write clears TI even when the match fires on the same edge.
            if (w_mtc0 && mtc0_addr == ADDR_COMPARE) begin
                r_compare <= mtc0_wdata;
                r_ti      <= 1'b0;
            end else if (r_count + 32'd1 == r_compare) begin
                r_ti <= 1'b1;
            end

            if (w_mtc0 && mtc0_addr == ADDR_STATUS) begin
                r_im  <= mtc0_wdata[15:8];
                r_exl <= mtc0_wdata[1];
                r_ie  <= mtc0_wdata[0];
            end
            if (w_mtc0 && mtc0_addr == ADDR_CAUSE) begin
                r_ip_sw <= mtc0_wdata[9:8];
            end
            if (w_mtc0 && mtc0_addr == ADDR_EPC) begin
                r_epc <= mtc0_wdata;
            end

            // Event updates come last so they override a same-cycle MTC0.
            case (w_event)
                EV_INT: begin
                    r_epc     <= wb_pc;
                    r_exccode <= 5'd0;
                    r_exl     <= 1'b1;
                end
                EV_SYS: begin
                    r_epc     <= wb_pc;
                    r_exccode <= 5'd8;
                    r_exl     <= 1'b1;
                end
                EV_ERET: r_exl <= 1'b0;
                default: ;
            endcase
            r_flush_eret <= (w_event == EV_ERET);
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_raddr)
            ADDR_COUNT:   cp0_rdata = r_count;
            ADDR_COMPARE: cp0_rdata = r_compare;
            ADDR_STATUS:  cp0_rdata = {16'd0, r_im, 6'd0, r_exl, r_ie};
            ADDR_CAUSE:   cp0_rdata = {1'b0, r_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'd0};
            ADDR_EPC:     cp0_rdata = r_epc;
            default:      cp0_rdata = 32'd0;
        endcase
    end

endmodule
